bsg_comm_link_pkt_splitter: RTL
===============================

# bsg_comm_link_pkt_splitter

Core-side transmit stage placed directly upstream of the comm link's core input port (`core_valid_i`/`core_data_i`/`core_ready_o`). It accepts wide packets of `beats_p*width_p` bits from the core and serializes them into `width_p`-bit beats, least-significant beat first, under valid/ready flow control. It withholds traffic until link calibration completes. It aborts and flushes a partially sent packet if calibration is lost, so the fuser never receives a torn packet after relink.

## Interface
- `width_p`, "inv": beat width. Equals the comm link's fused `width_p`.
- `beats_p`, "inv": beats per packet, ≥1.
- `clk_i` input 1: core clock, same clock as the comm link's `core_clk_i`.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `calib_done_i` input 1: comm link `core_calib_done_r_o`, synchronous to `clk_i`.
- `pkt_v_i` input 1: packet valid.
- `pkt_data_i` input `beats_p*width_p`: packet; beat k is bits `[k*width_p +: width_p]`.
- `pkt_ready_o` output 1: packet accepted when `pkt_v_i & pkt_ready_o`.
- `v_o` output 1: beat valid, to comm link `core_valid_i`.
- `data_o` output `width_p`: beat, to `core_data_i`.
- `ready_i` input 1: from `core_ready_o`.
- `last_o` output 1: current beat is the final beat of its packet.
- `abort_o` output 1: one-cycle pulse; a partial packet was discarded.

## Operation
- Two states: IDLE and SEND. State is held in a typedef enum.
- Datapath:
  - Shift register `sr` of `beats_p*width_p` bits.
  - Beat counter `cnt` of width `max(1,$clog2(beats_p))`.
  - `data_o = sr[width_p-1:0]`.
  - `last_o = (state==SEND) & (cnt==beats_p-1)`.
- `v_o = (state==SEND) & calib_done_i`.
- `pkt_ready_o = calib_done_i & ((state==IDLE) | (last_o & ready_i))`. This allows back-to-back packets with zero bubble.
- Packet accept (`pkt_v_i & pkt_ready_o`): `sr <= pkt_data_i`, `cnt <= 0`, state goes to SEND. This takes priority over the last-beat return to IDLE.
- Beat handshake (`v_o & ready_i`), not last: `sr <= sr >> width_p` with zero fill, `cnt <= cnt+1`.
- Beat handshake on the last beat with no new accept: state goes to IDLE, `cnt <= 0`.
- `v_o & ~ready_i`: `sr`, `cnt` and state hold, so `data_o` is stable.
- Calibration loss (`~calib_done_i` while in SEND):
  - State goes to IDLE, `cnt <= 0` and `sr` is left stale.
  - `abort_o` goes high on the following cycle for exactly one cycle.
  - The remainder of that packet is never emitted.
  - If the drop persists, there is no repeat pulse.
- `calib_done_i` low in IDLE: no accept and no pulse.
- `beats_p==1`: every beat is last. SEND lasts one handshake and the shifter degenerates to a register.

## Timing
- Reset values (async assert, sync deassert is handled by the integrator):
  - State IDLE, `cnt` 0, `sr` 0, `abort_o` 0.
  - Hence `v_o` 0, `last_o` 0, `data_o` 0.
  - `pkt_ready_o` equals `calib_done_i`, which is 0 out of reset.
- Latency: the first beat is on `data_o` with `v_o` high in the cycle after packet accept. The packet occupies `beats_p` cycles under continuous `ready_i`.
- Throughput is one beat per cycle, sustained across packets.
- Combinational paths:
  - `ready_i` → `pkt_ready_o`.
  - `calib_done_i` → `v_o` and `pkt_ready_o`.
  - No `pkt_v_i` → `v_o` path.
- `v_o` never deasserts without a handshake, except on calibration loss or reset.
- Reset mid-packet discards the packet and produces no `abort_o` pulse.

## Structure
- Put the state enum (`IDLE`, `SEND`) in `bsg_comm_link_pkg` as `bsg_comm_link_tx_state_e`.
- No sub-module. The counter and shifter are inline, because existing counter primitives use synchronous active-high reset, which conflicts with this block's reset.

## Test plan
- Calibration low, `pkt_v_i`=1 for 10 cycles → `pkt_ready_o`=0 and `v_o`=0 throughout. Raise `calib_done_i` → accept on that cycle.
- `width_p`=16, `beats_p`=4, packet `64'h4444_3333_2222_1111`, `ready_i`=1 → `data_o` = 1111, 2222, 3333, 4444 on 4 consecutive cycles, with `last_o` only on 4444.
- Two packets back-to-back, `ready_i`=1 → 8 consecutive valid beats with no bubble, and `pkt_ready_o` high in the 4444 cycle.
- `ready_i` toggling 1,0,0,1,… → `data_o` stable while `v_o & ~ready_i`, and the beat order is unchanged.
- Drop `calib_done_i` after beat 2222 is taken → `v_o` is 0 in the same cycle, `abort_o` pulses once, and after recalibration the next packet starts at beat 0.
- Assert `reset_n_i` low mid-packet → all outputs take reset values immediately, with no `abort_o` pulse. Repeat scenario 2 with `beats_p`=1 → one beat per cycle, `last_o` always 1.

Source files
------------

// File: rtl/bsg_comm_link_pkg.sv
// Purpose: shared types for the comm link core-side transmit path.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package bsg_comm_link_pkg;

    // Transmit stage state: IDLE waits for a packet, SEND streams its beats.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } bsg_comm_link_tx_state_e;

    // Counter width that stays legal when only one value is needed.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_comm_link_pkt_splitter.sv
// Purpose: serialize beats_p*width_p packets into width_p beats, LS beat first; hold off until calibrated, flush on calibration loss.
// Latency: first beat valid the cycle after accept; beats_p cycles per packet, back-to-back with no bubble.
// Backpressure: ready_i low freezes the current beat; a new packet is taken only when idle or when the last beat hands off.
//
// Ports:
//   clk_i, reset_n_i        core clock, async active-low reset
//   calib_done_i            link calibrated (synchronous to clk_i)
//   pkt_v_i/pkt_data_i/pkt_ready_o  wide packet input, valid/ready
//   v_o/data_o/ready_i      beat output to the comm link core port
//   last_o                  current beat is the final beat of its packet
//   abort_o                 one-cycle pulse: a partially sent packet was dropped
module bsg_comm_link_pkt_splitter
    import bsg_comm_link_pkg::*;
#(
    parameter int width_p = 16,
    parameter int beats_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         calib_done_i,
    input  logic                         pkt_v_i,
    input  logic [beats_p*width_p-1:0]   pkt_data_i,
    output logic                         pkt_ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i,
    output logic                         last_o,
    output logic                         abort_o
);

    localparam int sr_w_lp  = beats_p * width_p;
    localparam int cnt_w_lp = safe_clog2(beats_p);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(beats_p - 1);

    bsg_comm_link_tx_state_e state_r, state_n;
    logic [cnt_w_lp-1:0]     cnt_r, cnt_n;
    logic [sr_w_lp-1:0]      sr_r, sr_n;
    logic                    abort_r, abort_n;

    logic accept;
    logic beat_hs;
    logic calib_lost;

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath registers: shifter, beat counter, abort pulse.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r   <= '0;
            sr_r    <= '0;
            abort_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_n;
            sr_r    <= sr_n;
            abort_r <= abort_n;
        end
    end

    // Next state and datapath.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        sr_n       = sr_r;
        abort_n    = 1'b0;
        accept     = pkt_v_i & pkt_ready_o;
        beat_hs    = v_o & ready_i;
        calib_lost = (state_r == SEND) & ~calib_done_i;

        if (calib_lost) begin
            // Drop the rest of the packet; the shifter is left stale since
            // nothing reads it until the next accept reloads it.
            state_n = IDLE;
            cnt_n   = '0;
            abort_n = 1'b1;
        end else if (accept) begin
            // Wins over the last-beat return to IDLE, giving zero-bubble
            // back-to-back packets.
            state_n = SEND;
            sr_n    = pkt_data_i;
            cnt_n   = '0;
        end else if (beat_hs) begin
            if (last_o) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                sr_n  = sr_r >> width_p;
                cnt_n = cnt_r + 1'b1;
            end
        end
    end

    // Outputs. calib_done_i gates v_o and pkt_ready_o combinationally so
    // nothing leaves in the cycle calibration drops.
    always_comb begin
        v_o         = (state_r == SEND) & calib_done_i;
        last_o      = (state_r == SEND) & (cnt_r == cnt_last_lp);
        pkt_ready_o = calib_done_i & ((state_r == IDLE) | (last_o & ready_i));
        data_o      = sr_r[width_p-1:0];
        abort_o     = abort_r;
    end

endmodule
